mux_nto1_pipe: RTL and testbench



---
 rtl/mux_nto1_pipe.sv | 141 ++++++++++++++
 tb/tb_mux_nto1_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// N-input word mux with one registered output stage, valid/ready on every port,
// external-select or round-robin selection. Define MUX_NTO1_XFER_CNT_EN to add the xfer_cnt output.
module mux_nto1_pipe #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 4,
  parameter int SEL_W    = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
`ifdef MUX_NTO1_XFER_CNT_EN
  ,
  output logic [15:0]             xfer_cnt
`endif
);

  localparam int NUM_SLOTS = 2**SEL_W;

  // Inputs padded out to the full index range so any SEL_W-bit index is safe to use.
  logic [WIDTH-1:0]     word_arr [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_ext;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < NUM_IN) begin : g_live
        assign word_arr[gi]  = in_data[gi*WIDTH +: WIDTH];
        assign valid_ext[gi] = in_valid[gi];
      end else begin : g_pad
        assign word_arr[gi]  = '0;
        assign valid_ext[gi] = 1'b0;
      end
    end
  endgenerate

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             space;
  logic             sel_in_range;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  int               probe;
  logic             choose_ok;
  logic [SEL_W-1:0] choose_idx;
  logic             xfer;

  assign space        = !out_valid_q || out_ready;
  assign sel_in_range = {1'b0, sel} < (SEL_W+1)'(NUM_IN);

  // Round-robin: first valid channel strictly after the last granted one.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    probe    = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      probe = (int'(ptr_q) + k) % NUM_IN;
      if (!rr_found && valid_ext[SEL_W'(probe)]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(probe);
      end
    end
  end

  assign choose_ok  = (ARB_MODE == 1) ? rr_found : sel_in_range;
  assign choose_idx = (ARB_MODE == 1) ? rr_idx   : sel;
  assign xfer       = choose_ok && valid_ext[choose_idx] && space;

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = space && choose_ok && (choose_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = word_arr[choose_idx];
      out_src_d   = choose_idx;
      if (ARB_MODE == 1) begin
        ptr_d = choose_idx;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef MUX_NTO1_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: select mode (4 and 3 inputs) and round-robin mode,
// with the transfer counter checked when MUX_NTO1_XFER_CNT_EN is defined.
module tb_mux_nto1_pipe;

  logic Clk;
  logic rst_a, rst_b, rst_c;

  logic [127:0] in_data_a;
  logic [3:0]   in_valid_a, in_ready_a;
  logic [1:0]   sel_a, out_src_a;
  logic [31:0]  out_data_a;
  logic         out_valid_a, out_ready_a;

  logic [95:0]  in_data_b;
  logic [2:0]   in_valid_b, in_ready_b;
  logic [1:0]   sel_b, out_src_b;
  logic [31:0]  out_data_b;
  logic         out_valid_b, out_ready_b;

  logic [127:0] in_data_c;
  logic [3:0]   in_valid_c, in_ready_c;
  logic [1:0]   sel_c, out_src_c;
  logic [31:0]  out_data_c;
  logic         out_valid_c, out_ready_c;

`ifdef MUX_NTO1_XFER_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

  int total;
  int bad;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .ARB_MODE(0)) u_sel4 (
    .Clk(Clk), .Rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .sel(sel_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_src(out_src_a)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .xfer_cnt(cnt_a)
`endif
  );

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ARB_MODE(0)) u_sel3 (
    .Clk(Clk), .Rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sel(sel_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_src(out_src_b)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .xfer_cnt(cnt_b)
`endif
  );

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .ARB_MODE(1)) u_rr4 (
    .Clk(Clk), .Rst(rst_c), .in_data(in_data_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .sel(sel_c), .out_data(out_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_src(out_src_c)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .xfer_cnt(cnt_c)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      $display("chk %s ok value=%0h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int rr_seq [6];
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_src;
    logic [31:0] exp_dat;

    rr_seq = '{0, 1, 2, 3, 0, 1};
    total = 0;
    bad   = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    in_data_a = '0; in_valid_a = '0; sel_a = '0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = '0; sel_b = '0; out_ready_b = 1'b0;
    in_data_c = '0; in_valid_c = '0; sel_c = '0; out_ready_c = 1'b0;

    step();
    step();
    chk("rst_valid_a", 64'(out_valid_a), 64'h0);
    chk("rst_data_a",  64'(out_data_a),  64'h0);
    chk("rst_src_a",   64'(out_src_a),   64'h0);
    chk("rst_valid_c", 64'(out_valid_c), 64'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Load a word, then pull reset low between edges.
    sel_a = 2'd0; in_valid_a = 4'b0001; in_data_a[31:0] = 32'h0000_0011;
    step();
    chk("pre_rst_valid", 64'(out_valid_a), 64'h1);
    chk("pre_rst_data",  64'(out_data_a),  64'h11);
    #2 rst_a = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid_a), 64'h0);
    chk("async_rst_data",  64'(out_data_a),  64'h0);
    chk("async_rst_src",   64'(out_src_a),   64'h0);
    rst_a = 1'b1;
    in_valid_a = 4'b0000;

    // Capture into a stalled output and hold.
    sel_a = 2'd2; in_valid_a = 4'b0100; in_data_a[95:64] = 32'hDEAD_BEEF; out_ready_a = 1'b0;
    #1 chk("ready_ch2", 64'(in_ready_a), 64'b0100);
    step();
    chk("cap_valid", 64'(out_valid_a), 64'h1);
    chk("cap_data",  64'(out_data_a),  64'hDEAD_BEEF);
    chk("cap_src",   64'(out_src_a),   64'h2);
    in_data_a[95:64] = 32'h1234_5678;
    sel_a = 2'd1; in_valid_a = 4'b0110; in_data_a[63:32] = 32'h0000_AAAA;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(in_ready_a), 64'h0);
      step();
      chk("stall_valid", 64'(out_valid_a), 64'h1);
      chk("stall_data",  64'(out_data_a),  64'hDEAD_BEEF);
      chk("stall_src",   64'(out_src_a),   64'h2);
    end
    out_ready_a = 1'b1;
    #1 chk("unstall_ready", 64'(in_ready_a), 64'b0010);
    step();
    chk("new_sel_data", 64'(out_data_a), 64'hAAAA);
    chk("new_sel_src",  64'(out_src_a),  64'h1);

    // Back-to-back transfers from channel 1 with the sink always ready.
    in_valid_a = 4'b0010;
    for (int v = 1; v <= 4; v++) begin
      in_data_a[63:32] = 32'(v);
      #1 chk("tput_ready", 64'(in_ready_a), 64'b0010);
      step();
      chk("tput_valid", 64'(out_valid_a), 64'h1);
      chk("tput_data",  64'(out_data_a),  64'(v));
    end
    in_valid_a = 4'b0000;
    step();
    chk("drain_valid", 64'(out_valid_a), 64'h0);
    chk("drain_hold",  64'(out_data_a),  64'h4);

    // Three-input instance: index 3 selects nothing.
    in_data_b = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    sel_b = 2'd3; in_valid_b = 3'b111; out_ready_b = 1'b1;
    #1 chk("badsel_ready", 64'(in_ready_b), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("badsel_valid", 64'(out_valid_b), 64'h0);
    end
    sel_b = 2'd2;
    #1 chk("sel2_ready", 64'(in_ready_b), 64'b100);
    step();
    chk("sel2_data", 64'(out_data_b), 64'hC2);
    chk("sel2_src",  64'(out_src_b),  64'h2);

    // Round-robin over all four channels.
    in_data_c = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    sel_c = 2'd3; in_valid_c = 4'b1111; out_ready_c = 1'b1;
    #1 chk("rr_first_ready", 64'(in_ready_c), 64'b0001);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_valid", 64'(out_valid_c), 64'h1);
      chk("rr_src",   64'(out_src_c),   64'(rr_seq[i]));
      chk("rr_data",  64'(out_data_c),  64'(32'h100 + rr_seq[i]));
    end
    in_valid_c = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_single_valid", 64'(out_valid_c), 64'h1);
      chk("rr_single_src",   64'(out_src_c),   64'h2);
    end

    // Round-robin under alternating backpressure, pointer restarted by reset.
    rst_c = 1'b0;
    #1 rst_c = 1'b1;
    in_valid_c = 4'b1010;
    in_data_c = {32'h0000_00B3, 32'h0000_0000, 32'h0000_00B1, 32'h0000_0000};
    for (int t = 0; t < 8; t++) begin
      out_ready_c = (t % 2 == 0);
      exp_src = ((t / 2) % 2 == 0) ? 2'd1 : 2'd3;
      exp_dat = (exp_src == 2'd1) ? 32'hB1 : 32'hB3;
      exp_rdy = (t % 2 == 0) ? ((exp_src == 2'd1) ? 4'b0010 : 4'b1000) : 4'b0000;
      #1 chk("bp_ready", 64'(in_ready_c), 64'(exp_rdy));
      step();
      chk("bp_valid", 64'(out_valid_c), 64'h1);
      chk("bp_src",   64'(out_src_c),   64'(exp_src));
      chk("bp_data",  64'(out_data_c),  64'(exp_dat));
    end

`ifdef MUX_NTO1_XFER_CNT_EN
    rst_a = 1'b0;
    #1 chk("cnt_rst0", 64'(cnt_a), 64'h0);
    rst_a = 1'b1;
    sel_a = 2'd0; in_valid_a = 4'b0001; out_ready_a = 1'b1;
    repeat (32'h10001) step();
    chk("cnt_wrap", 64'(cnt_a), 64'h1);
    in_valid_a = 4'b0000;
    rst_a = 1'b0;
    #1 chk("cnt_rst1", 64'(cnt_a), 64'h0);
    rst_a = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
